dll_tx_fc_gate: RTL and testbench
=================================

Name: dll_tx_fc_gate

Overview:
- Transmit-side flow-control credit gate. Sits directly downstream of the DLLP receive handler.
- Consumes the handler's per-type credit limits (tx_fc_*), its fc1_values_stored flag and its update_fc pulse.
- Tracks credits consumed by outgoing TLPs and accepts a TLP from the transaction-layer scheduler only when the link partner has advertised enough header and data credits for that TLP's type.

Parameters:
- HDR_CRED_WIDTH, 8, header credit counter width (PCIe: 8).
- DATA_CRED_WIDTH, 12, data credit counter width (PCIe: 12).
- TLP_DCRED_WIDTH, 10, width of per-TLP data credit request (max 1023 credits).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- phy_link_up_i  input  1  link up; low forces re-init
- fc1_values_stored_i  input  1  all three InitFC1 types received
- update_fc_i  input  1  one-cycle pulse, limits below refreshed
- tx_fc_ph_i  input  HDR_CRED_WIDTH  posted header credit limit
- tx_fc_pd_i  input  DATA_CRED_WIDTH  posted data credit limit
- tx_fc_nph_i  input  HDR_CRED_WIDTH  non-posted header limit
- tx_fc_npd_i  input  DATA_CRED_WIDTH  non-posted data limit
- tx_fc_cplh_i  input  HDR_CRED_WIDTH  completion header limit
- tx_fc_cpld_i  input  DATA_CRED_WIDTH  completion data limit
- tlp_req_vld_i  input  1  TLP request valid
- tlp_req_type_i  input  2  0=P, 1=NP, 2=Cpl, 3=reserved
- tlp_req_dcred_i  input  TLP_DCRED_WIDTH  data credits needed (0 = no payload)
- tlp_req_rdy_o  output  1  request accepted this cycle when vld&&rdy
- fc_init_done_o  output  1  limits latched, gating active
- fc_stall_o  output  3  registered per-type stall flags [P,NP,Cpl]

Behaviour:
- Reset (async assert, sync release): state ST_INIT; all consumed counters 0; all limits 0; infinite flags 0; tlp_req_rdy_o=0; fc_init_done_o=0; fc_stall_o=0.
- ST_INIT:
  - tlp_req_rdy_o=0.
  - On the first cycle with fc1_values_stored_i=1 and phy_link_up_i=1: latch all six limits.
  - Set the infinite flag for each field whose latched value is 0.
  - Clear consumed counters; go to ST_ACTIVE. fc_init_done_o=1 from the next cycle.
- ST_ACTIVE:
  - phy_link_up_i=0 -> next cycle ST_INIT, consumed counters and flags cleared, fc_init_done_o=0.
  - update_fc_i=1 -> reload all six limits from the inputs, except fields with the infinite flag set (stay infinite, value ignored). Effective at the next edge.
- Credit check for the selected type, combinational:
  - hdr_ok = hinf || ((limit_h - (cons_h + 1)) mod 2^HDR_CRED_WIDTH) <= 2^(HDR_CRED_WIDTH-1).
  - data_ok = dinf || dcred==0 || ((limit_d - (cons_d + dcred)) mod 2^DATA_CRED_WIDTH) <= 2^(DATA_CRED_WIDTH-1). dcred is zero-extended.
  - All arithmetic is modular at counter width; wrap-around is legal.
- Handshake:
  - tlp_req_rdy_o = ST_ACTIVE && tlp_req_vld_i && type!=3 && hdr_ok && data_ok. This is a combinational path from the req inputs.
  - Type 3 is never accepted; its stall flag is not set.
  - On vld&&rdy: cons_h += 1 and cons_d += dcred (modulo) at that edge. Back-to-back acceptance every cycle is allowed.
  - Request inputs must stay stable while vld=1 and rdy=0.
- Simultaneous update_fc_i and acceptance in one cycle:
  - The check uses the current (old) limits.
  - Consumed increment and limit reload both take effect at the same edge.
- fc_stall_o[t] <= vld && type==t && !rdy (ST_ACTIVE only); otherwise 0. One cycle latency.
- Consumed counters are never decremented; only reset or link-down clears them.

Test Plan:
- Init: PH=4, PD=64, NPH=0, NPD=0, CPLH=0, CPLD=0; pulse fc1_values_stored_i -> fc_init_done_o=1 one cycle later; NP/Cpl treated as infinite.
- Posted exhaustion: 5 back-to-back P requests with dcred=2 -> first 4 accepted on consecutive cycles; 5th rdy=0, fc_stall_o=3'b001 next cycle; cons_h=4, cons_d=8.
- Update release: while the 5th request is held, update_fc_i with PH=8 -> rdy=1 the cycle after the pulse; cons_h=5.
- Data limit: PD=64, cons_d=60 -> P request dcred=8 blocked; changed to dcred=4 -> accepted, cons_d=64.
- Wrap: limit PH=0x02, cons_h=0xFF -> P request accepted ((0x02-0x00) mod 256 = 2 <= 128), cons_h=0x00; with limit 0xFF, cons_h=0xFF -> blocked.
- Infinite/reset/link-down:
  - 300 consecutive NP requests, dcred=1 -> all accepted.
  - phy_link_up_i drop -> ST_INIT, rdy=0, fc_init_done_o=0.
  - rst_i asserted mid-burst -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dll_tx_fc_gate_if.sv
// TLP request handshake between the transaction-layer scheduler (master)
// and the transmit flow-control credit gate (slave).
interface dll_tx_fc_gate_if #(
  parameter int unsigned TLP_DCRED_WIDTH = 10
);
  logic                       tlp_req_vld;
  logic [1:0]                 tlp_req_type;
  logic [TLP_DCRED_WIDTH-1:0] tlp_req_dcred;
  logic                       tlp_req_rdy;

  modport master (
    output tlp_req_vld,
    output tlp_req_type,
    output tlp_req_dcred,
    input  tlp_req_rdy
  );

  modport slave (
    input  tlp_req_vld,
    input  tlp_req_type,
    input  tlp_req_dcred,
    output tlp_req_rdy
  );
endinterface

// File: rtl/dll_tx_fc_gate.sv
// Transmit flow-control credit gate: accepts a TLP only when the link partner has
// advertised enough header and data credits for its type (P, NP, Cpl).
module dll_tx_fc_gate #(
  parameter int unsigned HDR_CRED_WIDTH  = 8,
  parameter int unsigned DATA_CRED_WIDTH = 12,
  parameter int unsigned TLP_DCRED_WIDTH = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       phy_link_up_i,
  input  logic                       fc1_values_stored_i,
  input  logic                       update_fc_i,
  input  logic [HDR_CRED_WIDTH-1:0]  tx_fc_ph_i,
  input  logic [DATA_CRED_WIDTH-1:0] tx_fc_pd_i,
  input  logic [HDR_CRED_WIDTH-1:0]  tx_fc_nph_i,
  input  logic [DATA_CRED_WIDTH-1:0] tx_fc_npd_i,
  input  logic [HDR_CRED_WIDTH-1:0]  tx_fc_cplh_i,
  input  logic [DATA_CRED_WIDTH-1:0] tx_fc_cpld_i,
  dll_tx_fc_gate_if.slave            tlp_req_io,
  output logic                       fc_init_done_o,
  output logic [2:0]                 fc_stall_o
);

  typedef logic [HDR_CRED_WIDTH-1:0]  hcred_t;
  typedef logic [DATA_CRED_WIDTH-1:0] dcred_t;

  localparam hcred_t HalfH = hcred_t'(1) << (HDR_CRED_WIDTH - 1);
  localparam dcred_t HalfD = dcred_t'(1) << (DATA_CRED_WIDTH - 1);

  typedef enum logic [0:0] {StInit, StActive} state_e;

  state_e state_q, state_d;

  // Per-type arrays are indexed by TLP type: 0=P, 1=NP, 2=Cpl.
  logic [2:0][HDR_CRED_WIDTH-1:0]  lim_h_q, lim_h_d, cons_h_q, cons_h_d, lim_h_in;
  logic [2:0][DATA_CRED_WIDTH-1:0] lim_d_q, lim_d_d, cons_d_q, cons_d_d, lim_d_in;
  logic [2:0]                      hinf_q, hinf_d, dinf_q, dinf_d;
  logic [2:0]                      stall_q, stall_d;

  logic                       in_active, latch_lim, link_drop, reload, accept;
  logic                       req_vld, req_rdy, type_ok, hdr_ok, data_ok;
  logic [1:0]                 sel;
  logic [TLP_DCRED_WIDTH-1:0] req_dcred;
  dcred_t                     dreq;
  hcred_t                     h_room;
  dcred_t                     d_room;

  assign req_vld   = tlp_req_io.tlp_req_vld;
  assign req_dcred = tlp_req_io.tlp_req_dcred;
  assign type_ok   = (tlp_req_io.tlp_req_type != 2'd3);
  assign sel       = type_ok ? tlp_req_io.tlp_req_type : 2'd0;
  assign dreq      = dcred_t'(req_dcred);

  assign lim_h_in = {tx_fc_cplh_i, tx_fc_nph_i, tx_fc_ph_i};
  assign lim_d_in = {tx_fc_cpld_i, tx_fc_npd_i, tx_fc_pd_i};

  // Modular distance to the limit; values past half the range mean "overshoot".
  assign h_room  = lim_h_q[sel] - (cons_h_q[sel] + hcred_t'(1));
  assign d_room  = lim_d_q[sel] - (cons_d_q[sel] + dreq);
  assign hdr_ok  = hinf_q[sel] || (h_room <= HalfH);
  assign data_ok = dinf_q[sel] || (req_dcred == '0) || (d_room <= HalfD);

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:   if (fc1_values_stored_i && phy_link_up_i) state_d = StActive;
      StActive: if (!phy_link_up_i) state_d = StInit;
      default:  state_d = StInit;
    endcase
  end

  // FSM outputs and datapath controls
  always_comb begin
    in_active = (state_q == StActive);
    latch_lim = (state_q == StInit) && fc1_values_stored_i && phy_link_up_i;
    link_drop = in_active && !phy_link_up_i;
    reload    = in_active && update_fc_i;
    req_rdy   = in_active && req_vld && type_ok && hdr_ok && data_ok;
    accept    = req_rdy;
    fc_init_done_o = in_active;
  end

  assign tlp_req_io.tlp_req_rdy = req_rdy;
  assign fc_stall_o             = stall_q;

  always_comb begin
    lim_h_d  = lim_h_q;
    lim_d_d  = lim_d_q;
    cons_h_d = cons_h_q;
    cons_d_d = cons_d_q;
    hinf_d   = hinf_q;
    dinf_d   = dinf_q;
    stall_d  = '0;
    if (latch_lim) begin
      lim_h_d  = lim_h_in;
      lim_d_d  = lim_d_in;
      cons_h_d = '0;
      cons_d_d = '0;
      for (int i = 0; i < 3; i++) begin
        hinf_d[i] = (lim_h_in[i] == '0);
        dinf_d[i] = (lim_d_in[i] == '0);
      end
    end else if (link_drop) begin
      cons_h_d = '0;
      cons_d_d = '0;
      hinf_d   = '0;
      dinf_d   = '0;
    end else begin
      // Reload and consumption both land on the same edge; the check used old limits.
      if (reload) begin
        for (int i = 0; i < 3; i++) begin
          if (!hinf_q[i]) lim_h_d[i] = lim_h_in[i];
          if (!dinf_q[i]) lim_d_d[i] = lim_d_in[i];
        end
      end
      if (accept) begin
        cons_h_d[sel] = cons_h_q[sel] + hcred_t'(1);
        cons_d_d[sel] = cons_d_q[sel] + dreq;
      end
    end
    if (in_active && req_vld && type_ok && !req_rdy) stall_d[sel] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lim_h_q  <= '0;
      lim_d_q  <= '0;
      cons_h_q <= '0;
      cons_d_q <= '0;
      hinf_q   <= '0;
      dinf_q   <= '0;
      stall_q  <= '0;
    end else begin
      lim_h_q  <= lim_h_d;
      lim_d_q  <= lim_d_d;
      cons_h_q <= cons_h_d;
      cons_d_q <= cons_d_d;
      hinf_q   <= hinf_d;
      dinf_q   <= dinf_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_dll_tx_fc_gate.sv
// Directed scoreboard bench for dll_tx_fc_gate: expected rdy/stall are queued as each
// request is driven and compared when the gate responds.
module tb_dll_tx_fc_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic        link, fc1, upd;
  logic [7:0]  ph, nph, cplh;
  logic [11:0] pd, npd, cpld;
  logic        done;
  logic [2:0]  fc_stall;
  logic        exp_done;

  int checks = 0;
  int errors = 0;

  logic       rdy_q[$];
  logic [2:0] stall_q[$];

  dll_tx_fc_gate_if #(.TLP_DCRED_WIDTH(10)) tlp ();

  dll_tx_fc_gate #(
    .HDR_CRED_WIDTH (8),
    .DATA_CRED_WIDTH(12),
    .TLP_DCRED_WIDTH(10)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .phy_link_up_i      (link),
    .fc1_values_stored_i(fc1),
    .update_fc_i        (upd),
    .tx_fc_ph_i         (ph),
    .tx_fc_pd_i         (pd),
    .tx_fc_nph_i        (nph),
    .tx_fc_npd_i        (npd),
    .tx_fc_cplh_i       (cplh),
    .tx_fc_cpld_i       (cpld),
    .tlp_req_io         (tlp.slave),
    .fc_init_done_o     (done),
    .fc_stall_o         (fc_stall)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // One clock cycle: drive at posedge+1, compare at the negedge, return at posedge+1.
  task automatic step(input logic v, input logic [1:0] t, input logic [9:0] d,
                      input logic u, input logic exp_rdy);
    logic [2:0] st;
    tlp.tlp_req_vld   = v;
    tlp.tlp_req_type  = t;
    tlp.tlp_req_dcred = d;
    upd               = u;
    rdy_q.push_back(exp_rdy);
    st = (exp_done && v && (t != 2'd3) && !exp_rdy) ? (3'b001 << t) : 3'b000;
    @(negedge clk);
    chk("rdy", {31'd0, tlp.tlp_req_rdy}, {31'd0, rdy_q.pop_front()});
    chk("stall", {29'd0, fc_stall}, {29'd0, stall_q.pop_front()});
    chk("done", {31'd0, done}, {31'd0, exp_done});
    stall_q.push_back(st);
    @(posedge clk);
    #1;
    upd = 1'b0;
  endtask

  initial begin
    rst = 1'b1; link = 1'b0; fc1 = 1'b0; upd = 1'b0; exp_done = 1'b0;
    ph = '0; pd = '0; nph = '0; npd = '0; cplh = '0; cpld = '0;
    tlp.tlp_req_vld = 1'b0; tlp.tlp_req_type = 2'd0; tlp.tlp_req_dcred = '0;
    stall_q.push_back(3'b000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", {31'd0, tlp.tlp_req_rdy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stall", {29'd0, fc_stall}, 32'd0);
    rst = 1'b0;

    // Init: NP/Cpl zero limits mean infinite credits
    ph = 8'd4; pd = 12'd64; link = 1'b1;
    step(1'b1, 2'd0, 10'd1, 1'b0, 1'b0);
    fc1 = 1'b1;
    step(1'b0, 2'd0, 10'd0, 1'b0, 1'b0);
    fc1 = 1'b0; exp_done = 1'b1;
    // Non-zero NP/Cpl inputs must be ignored by later updates
    nph = 8'd1; npd = 12'd1; cplh = 8'd1; cpld = 12'd1;
    step(1'b0, 2'd0, 10'd0, 1'b0, 1'b0);

    // Posted header exhaustion, then release by update
    repeat (4) step(1'b1, 2'd0, 10'd2, 1'b0, 1'b1);
    step(1'b1, 2'd0, 10'd2, 1'b0, 1'b0);
    ph = 8'd8;
    step(1'b1, 2'd0, 10'd2, 1'b1, 1'b0);
    step(1'b1, 2'd0, 10'd2, 1'b0, 1'b1);         // cons_h=5 cons_d=10

    // Data limit
    step(1'b1, 2'd0, 10'd50, 1'b0, 1'b1);        // cons_d=60 cons_h=6
    step(1'b1, 2'd0, 10'd8, 1'b0, 1'b0);
    step(1'b1, 2'd0, 10'd4, 1'b0, 1'b1);         // cons_d=64 cons_h=7
    step(1'b1, 2'd0, 10'd0, 1'b0, 1'b1);         // no payload bypasses data check, cons_h=8
    step(1'b1, 2'd0, 10'd0, 1'b0, 1'b0);

    // Header wrap-around
    ph = 8'h88;
    step(1'b1, 2'd0, 10'd0, 1'b1, 1'b0);
    repeat (128) step(1'b1, 2'd0, 10'd0, 1'b0, 1'b1);  // cons_h=0x88
    step(1'b1, 2'd0, 10'd0, 1'b0, 1'b0);
    ph = 8'hFF;
    step(1'b1, 2'd0, 10'd0, 1'b1, 1'b0);
    repeat (119) step(1'b1, 2'd0, 10'd0, 1'b0, 1'b1);  // cons_h=0xFF
    step(1'b1, 2'd0, 10'd0, 1'b0, 1'b0);
    ph = 8'h02;
    step(1'b1, 2'd0, 10'd0, 1'b1, 1'b0);
    step(1'b1, 2'd0, 10'd0, 1'b0, 1'b1);         // cons_h wraps to 0x00
    step(1'b1, 2'd0, 10'd0, 1'b0, 1'b1);
    step(1'b1, 2'd0, 10'd0, 1'b0, 1'b1);         // cons_h=2
    step(1'b1, 2'd0, 10'd0, 1'b0, 1'b0);

    // Update and acceptance on the same edge
    ph = 8'h03;
    step(1'b1, 2'd0, 10'd0, 1'b1, 1'b0);
    ph = 8'h04;
    step(1'b1, 2'd0, 10'd0, 1'b1, 1'b1);         // old limit 3 admits; cons_h=3, limit 4
    step(1'b1, 2'd0, 10'd0, 1'b0, 1'b1);
    step(1'b1, 2'd0, 10'd0, 1'b0, 1'b0);

    // Reserved type, infinite NP and Cpl
    step(1'b1, 2'd3, 10'd0, 1'b0, 1'b0);
    repeat (300) step(1'b1, 2'd1, 10'd1, 1'b0, 1'b1);
    step(1'b1, 2'd2, 10'h3FF, 1'b0, 1'b1);

    // Link down
    link = 1'b0;
    step(1'b1, 2'd1, 10'd1, 1'b0, 1'b1);
    exp_done = 1'b0;
    step(1'b1, 2'd1, 10'd1, 1'b0, 1'b0);
    step(1'b1, 2'd0, 10'd0, 1'b0, 1'b0);

    // Re-init: counters and infinite flags must start fresh
    ph = 8'd1; pd = 12'd0; nph = 8'd2; npd = 12'd4; cplh = 8'd0; cpld = 12'd0;
    link = 1'b1; fc1 = 1'b1;
    step(1'b0, 2'd0, 10'd0, 1'b0, 1'b0);
    fc1 = 1'b0; exp_done = 1'b1;
    step(1'b1, 2'd0, 10'h3FF, 1'b0, 1'b1);       // PD infinite
    step(1'b1, 2'd0, 10'd0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 10'd4, 1'b0, 1'b1);
    step(1'b1, 2'd1, 10'd1, 1'b0, 1'b0);         // NP data exhausted

    // Asynchronous reset mid-burst
    tlp.tlp_req_vld = 1'b1; tlp.tlp_req_type = 2'd1; tlp.tlp_req_dcred = 10'd0;
    #2;
    chk("pre_rst_rdy", {31'd0, tlp.tlp_req_rdy}, 32'd1);
    chk("pre_rst_stall", {29'd0, fc_stall}, {29'd0, stall_q.pop_front()});
    chk("pre_rst_done", {31'd0, done}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_rdy", {31'd0, tlp.tlp_req_rdy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_stall", {29'd0, fc_stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
